// File: rtl/rv32im_pkg.sv
// rv32im_pkg
// Shared definitions for the rv32im writeback slice: default data and
// register-address widths, the writeback requester indices used by the
// round-robin arbiter, and a helper that advances a requester index
// cyclically.
package rv32im_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int REG_BITS_DEF = 5;
  localparam int NUM_WB_REQ   = 3;

  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_MD  = 2'd2
  } req_e;

  // Cyclic advance over the NUM_WB_REQ requesters; off is always < NUM_WB_REQ.
  function automatic req_e req_add(input req_e base, input int unsigned off);
    int unsigned sum;
    sum = int'(base) + off;
    if (sum >= NUM_WB_REQ) sum = sum - NUM_WB_REQ;
    return req_e'(sum[1:0]);
  endfunction

endpackage

// File: rtl/rv32im_scoreboard.sv
// rv32im_scoreboard
// Busy-register scoreboard for long-latency (load, mul/div) destinations.
// Produces the decode stall for RAW/WAW hazards and a sticky error flag
// when a long-latency writeback targets a register that was never marked busy.
// Ports:
//   clk_i, reset_ni         clock, async active-low reset
//   dec_valid_i             decoder holds a valid instruction
//   dec_rs1_i/rs2_i/rd_i    decoded operand / destination addresses
//   dec_long_i, issue_i     long-latency instruction, issued this cycle
//   long_gnt_i, long_rd_i   MEM/MD writeback granted this cycle and its rd
//   clr_i, clr_rd_i         registered long-latency write (clears busy)
//   busy_o, stall_o, err_o  scoreboard vector, hazard stall, sticky error
module rv32im_scoreboard
  import rv32im_pkg::*;
#(
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   dec_valid_i,
  input  logic [REG_BITS-1:0]    dec_rs1_i,
  input  logic [REG_BITS-1:0]    dec_rs2_i,
  input  logic [REG_BITS-1:0]    dec_rd_i,
  input  logic                   dec_long_i,
  input  logic                   issue_i,
  input  logic                   long_gnt_i,
  input  logic [REG_BITS-1:0]    long_rd_i,
  input  logic                   clr_i,
  input  logic [REG_BITS-1:0]    clr_rd_i,
  output logic [2**REG_BITS-1:0] busy_o,
  output logic                   stall_o,
  output logic                   err_o
);

  localparam int NREGS = 2**REG_BITS;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             set_busy;
  logic             err_q;

  assign stall_o  = dec_valid_i & (busy_q[dec_rs1_i] | busy_q[dec_rs2_i] | busy_q[dec_rd_i]);
  assign set_busy = issue_i & ~stall_o & dec_long_i & (dec_rd_i != '0);

  // Clear is applied before set so a same-register set wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    if (set_busy) busy_d[dec_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (long_gnt_i && (long_rd_i != '0) && !busy_q[long_rd_i]) err_q <= 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule

// File: rtl/rv32im_wb_arbiter.sv
// rv32im_wb_arbiter
// Sequences the register-file write port between the ALU, load unit and
// mul/div unit with a per-cycle round-robin grant, and drives the register
// file from a registered output stage. The scoreboard sub-module tracks
// long-latency destinations and raises the decode stall.
// Ports:
//   clk_i, reset_ni                    clock, async active-low reset
//   alu_/mem_/md_ valid_i rd_i data_i   writeback requests
//   alu_/mem_/md_ ready_o               grant (transfer on valid & ready)
//   dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_long_i, issue_i
//                                      decoder hazard interface
//   stall_o                            decoder must not issue
//   write_o, rd_addr_o, data_o         register-file write port
//   busy_o, err_o                      scoreboard vector, sticky error
module rv32im_wb_arbiter
  import rv32im_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   alu_valid_i,
  input  logic [REG_BITS-1:0]    alu_rd_i,
  input  logic [XLEN-1:0]        alu_data_i,
  output logic                   alu_ready_o,
  input  logic                   mem_valid_i,
  input  logic [REG_BITS-1:0]    mem_rd_i,
  input  logic [XLEN-1:0]        mem_data_i,
  output logic                   mem_ready_o,
  input  logic                   md_valid_i,
  input  logic [REG_BITS-1:0]    md_rd_i,
  input  logic [XLEN-1:0]        md_data_i,
  output logic                   md_ready_o,
  input  logic                   dec_valid_i,
  input  logic [REG_BITS-1:0]    dec_rs1_i,
  input  logic [REG_BITS-1:0]    dec_rs2_i,
  input  logic [REG_BITS-1:0]    dec_rd_i,
  input  logic                   dec_long_i,
  input  logic                   issue_i,
  output logic                   stall_o,
  output logic                   write_o,
  output logic [REG_BITS-1:0]    rd_addr_o,
  output logic [XLEN-1:0]        data_o,
  output logic [2**REG_BITS-1:0] busy_o,
  output logic                   err_o
);

  req_e                  ptr_q;
  logic [NUM_WB_REQ-1:0] req_vld_p0;
  logic                  gnt_vld_p0;
  req_e                  gnt_idx_p0;
  logic [REG_BITS-1:0]   win_rd_p0;
  logic [XLEN-1:0]       win_data_p0;
  logic                  long_gnt_p0;
  logic                  out_long_p1;

  assign req_vld_p0 = {md_valid_i, mem_valid_i, alu_valid_i};

  // Stage p0: round-robin search starting at the pointer. Grants are
  // suppressed while reset is asserted so no requester sees ready.
  always_comb begin
    req_e cand;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = REQ_ALU;
    for (int i = 0; i < NUM_WB_REQ; i++) begin
      cand = req_add(ptr_q, i);
      if (!gnt_vld_p0 && req_vld_p0[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand;
      end
    end
    if (!reset_ni) gnt_vld_p0 = 1'b0;
  end

  always_comb begin
    win_rd_p0   = alu_rd_i;
    win_data_p0 = alu_data_i;
    case (gnt_idx_p0)
      REQ_MEM: begin win_rd_p0 = mem_rd_i; win_data_p0 = mem_data_i; end
      REQ_MD:  begin win_rd_p0 = md_rd_i;  win_data_p0 = md_data_i;  end
      default: begin win_rd_p0 = alu_rd_i; win_data_p0 = alu_data_i; end
    endcase
  end

  assign alu_ready_o = gnt_vld_p0 && (gnt_idx_p0 == REQ_ALU);
  assign mem_ready_o = gnt_vld_p0 && (gnt_idx_p0 == REQ_MEM);
  assign md_ready_o  = gnt_vld_p0 && (gnt_idx_p0 == REQ_MD);
  assign long_gnt_p0 = gnt_vld_p0 && (gnt_idx_p0 != REQ_ALU);

  // Stage p1: registered write port. An rd==0 winner is consumed without
  // a write; address/data hold when nothing is granted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      write_o     <= 1'b0;
      rd_addr_o   <= '0;
      data_o      <= '0;
      out_long_p1 <= 1'b0;
      ptr_q       <= REQ_MEM;
    end else begin
      write_o     <= gnt_vld_p0 && (win_rd_p0 != '0);
      out_long_p1 <= long_gnt_p0;
      if (gnt_vld_p0) begin
        rd_addr_o <= win_rd_p0;
        data_o    <= win_data_p0;
        ptr_q     <= req_add(gnt_idx_p0, 1);
      end
    end
  end

  rv32im_scoreboard #(
    .REG_BITS(REG_BITS)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .dec_valid_i(dec_valid_i),
    .dec_rs1_i  (dec_rs1_i),
    .dec_rs2_i  (dec_rs2_i),
    .dec_rd_i   (dec_rd_i),
    .dec_long_i (dec_long_i),
    .issue_i    (issue_i),
    .long_gnt_i (long_gnt_p0),
    .long_rd_i  (win_rd_p0),
    .clr_i      (write_o & out_long_p1),
    .clr_rd_i   (rd_addr_o),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .err_o      (err_o)
  );

endmodule

// File: tb/tb_rv32im_wb_arbiter.sv
// tb_rv32im_wb_arbiter
// Directed bench for rv32im_wb_arbiter: reset values, round-robin order,
// registered write port, scoreboard set/clear/stall, rd==0 handling and the
// sticky error flag.
module tb_rv32im_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;
  localparam int NREGS    = 32;

  logic                clk_i = 1'b0;
  logic                reset_ni = 1'b0;
  logic                alu_valid_i, mem_valid_i, md_valid_i;
  logic [REG_BITS-1:0] alu_rd_i, mem_rd_i, md_rd_i;
  logic [XLEN-1:0]     alu_data_i, mem_data_i, md_data_i;
  logic                alu_ready_o, mem_ready_o, md_ready_o;
  logic                dec_valid_i, dec_long_i, issue_i;
  logic [REG_BITS-1:0] dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic                stall_o, write_o, err_o;
  logic [REG_BITS-1:0] rd_addr_o;
  logic [XLEN-1:0]     data_o;
  logic [NREGS-1:0]    busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rv32im_wb_arbiter #(.XLEN(XLEN), .REG_BITS(REG_BITS)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
    .md_valid_i(md_valid_i), .md_rd_i(md_rd_i), .md_data_i(md_data_i), .md_ready_o(md_ready_o),
    .dec_valid_i(dec_valid_i), .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_long_i(dec_long_i), .issue_i(issue_i), .stall_o(stall_o),
    .write_o(write_o), .rd_addr_o(rd_addr_o), .data_o(data_o), .busy_o(busy_o), .err_o(err_o)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read then too.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_i = 0; alu_rd_i = '0; alu_data_i = '0;
    mem_valid_i = 0; mem_rd_i = '0; mem_data_i = '0;
    md_valid_i  = 0; md_rd_i  = '0; md_data_i  = '0;
    dec_valid_i = 0; dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0;
    dec_long_i  = 0; issue_i = 0;
  endtask

  task automatic do_reset();
    reset_ni = 0;
    idle_inputs();
    tick(); tick();
    reset_ni = 1;
  endtask

  function automatic logic [2:0] ready_vec();
    return {md_ready_o, mem_ready_o, alu_ready_o};
  endfunction

  task automatic test_reset();
    reset_ni = 0;
    idle_inputs();
    tick(); tick();
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL reset_write got=%0b exp=0", write_o); end
    checks++; if (rd_addr_o !== '0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr_o); end
    checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
    checks++; if (busy_o !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall_o); end
    reset_ni = 1;
  endtask

  task automatic test_round_robin();
    int          exp_idx [6] = '{1, 2, 0, 1, 2, 0};
    logic [31:0] src_data [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    logic [2:0]  exp_rdy;
    alu_valid_i = 1; alu_rd_i = 5'd1; alu_data_i = src_data[0];
    mem_valid_i = 1; mem_rd_i = 5'd2; mem_data_i = src_data[1];
    md_valid_i  = 1; md_rd_i  = 5'd3; md_data_i  = src_data[2];
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy = 3'b001 << exp_idx[i];
      checks++; if (ready_vec() !== exp_rdy) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, ready_vec(), exp_rdy); end
      tick();
      checks++; if (write_o !== 1'b1) begin failures++; $display("FAIL rr_write[%0d] got=%0b exp=1", i, write_o); end
      checks++; if (rd_addr_o !== 5'(exp_idx[i] + 1)) begin failures++; $display("FAIL rr_rd_addr[%0d] got=%0d exp=%0d", i, rd_addr_o, exp_idx[i] + 1); end
      checks++; if (data_o !== src_data[exp_idx[i]]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, data_o, src_data[exp_idx[i]]); end
    end
  endtask

  task automatic test_reset_mid_traffic();
    // Requests are still held from the round-robin test; two more grants
    // (MEM, MD) leave the pointer at ALU before reset.
    tick(); tick();
    reset_ni = 0;
    tick();
    checks++; if (ready_vec() !== 3'b000) begin failures++; $display("FAIL mid_reset_ready got=%b exp=000", ready_vec()); end
    checks++; if (write_o !== 1'b0 || rd_addr_o !== '0 || data_o !== '0) begin failures++; $display("FAIL mid_reset_port got=%0b/%0d/%h exp=0/0/0", write_o, rd_addr_o, data_o); end
    checks++; if (busy_o !== '0 || err_o !== 1'b0) begin failures++; $display("FAIL mid_reset_sb got=%h/%0b exp=0/0", busy_o, err_o); end
    reset_ni = 1;
    #1;
    checks++; if (ready_vec() !== 3'b010) begin failures++; $display("FAIL post_reset_first got=%b exp=010", ready_vec()); end
    tick();
    checks++; if (write_o !== 1'b1 || rd_addr_o !== 5'd2 || data_o !== 32'h2222_0002) begin failures++; $display("FAIL post_reset_write got=%0b/%0d/%h exp=1/2/22220002", write_o, rd_addr_o, data_o); end
    idle_inputs();
  endtask

  task automatic test_scoreboard_load();
    dec_valid_i = 1; dec_rd_i = 5'd5; dec_rs1_i = 5'd1; dec_rs2_i = 5'd2; dec_long_i = 1; issue_i = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL ld_issue_stall got=%0b exp=0", stall_o); end
    tick();
    issue_i = 0; dec_long_i = 0; dec_rs1_i = 5'd5; dec_rd_i = 5'd6;
    #1;
    checks++; if (busy_o !== 32'h0000_0020) begin failures++; $display("FAIL ld_busy_set got=%h exp=00000020", busy_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL ld_raw_stall got=%0b exp=1", stall_o); end
    mem_valid_i = 1; mem_rd_i = 5'd5; mem_data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (mem_ready_o !== 1'b1) begin failures++; $display("FAIL ld_mem_ready got=%0b exp=1", mem_ready_o); end
    tick();
    mem_valid_i = 0;
    checks++; if (write_o !== 1'b1 || rd_addr_o !== 5'd5 || data_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_write got=%0b/%0d/%h exp=1/5/deadbeef", write_o, rd_addr_o, data_o); end
    checks++; if (busy_o !== 32'h0000_0020) begin failures++; $display("FAIL ld_busy_hold got=%h exp=00000020", busy_o); end
    tick();
    checks++; if (busy_o !== '0) begin failures++; $display("FAIL ld_busy_clear got=%h exp=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL ld_stall_release got=%0b exp=0", stall_o); end
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL ld_write_idle got=%0b exp=0", write_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL ld_err got=%0b exp=0", err_o); end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    alu_valid_i = 1; alu_rd_i = '0; alu_data_i = 32'h0000_1234;
    #1;
    checks++; if (alu_ready_o !== 1'b1) begin failures++; $display("FAIL rd0_ready got=%0b exp=1", alu_ready_o); end
    tick();
    alu_valid_i = 0;
    checks++; if (write_o !== 1'b0) begin failures++; $display("FAIL rd0_write got=%0b exp=0", write_o); end
    checks++; if (rd_addr_o !== '0 || data_o !== 32'h0000_1234) begin failures++; $display("FAIL rd0_port got=%0d/%h exp=0/00001234", rd_addr_o, data_o); end
    dec_valid_i = 1; dec_rd_i = '0; dec_long_i = 1; issue_i = 1;
    tick();
    idle_inputs();
    checks++; if (busy_o !== '0) begin failures++; $display("FAIL rd0_busy got=%h exp=0", busy_o); end
  endtask

  task automatic test_waw_stall();
    dec_valid_i = 1; dec_rd_i = 5'd9; dec_long_i = 1; issue_i = 1;
    tick();
    checks++; if (busy_o !== 32'h0000_0200) begin failures++; $display("FAIL waw_busy_set got=%h exp=00000200", busy_o); end
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL waw_stall got=%0b exp=1", stall_o); end
    tick();
    // RAW on x9 while issuing a long op to x10: the issue must be dropped.
    dec_rd_i = 5'd10; dec_rs1_i = 5'd9;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL raw_stall got=%0b exp=1", stall_o); end
    tick();
    checks++; if (busy_o !== 32'h0000_0200) begin failures++; $display("FAIL stalled_issue_busy got=%h exp=00000200", busy_o); end
    idle_inputs();
    md_valid_i = 1; md_rd_i = 5'd9; md_data_i = 32'hCAFE_0009;
    tick();
    md_valid_i = 0;
    checks++; if (write_o !== 1'b1 || rd_addr_o !== 5'd9 || data_o !== 32'hCAFE_0009) begin failures++; $display("FAIL md_write got=%0b/%0d/%h exp=1/9/cafe0009", write_o, rd_addr_o, data_o); end
    tick();
    checks++; if (busy_o !== '0 || err_o !== 1'b0) begin failures++; $display("FAIL md_clear got=%h/%0b exp=0/0", busy_o, err_o); end
  endtask

  task automatic test_err_sticky();
    md_valid_i = 1; md_rd_i = 5'd7; md_data_i = 32'h7777_0007;
    #1;
    checks++; if (md_ready_o !== 1'b1) begin failures++; $display("FAIL err_md_ready got=%0b exp=1", md_ready_o); end
    tick();
    md_valid_i = 0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", err_o); end
    repeat (10) tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err_o); end
    reset_ni = 0;
    #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_reset got=%0b exp=0", err_o); end
    tick();
    reset_ni = 1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_reset_mid_traffic();
    do_reset();
    test_scoreboard_load();
    test_rd_zero();
    test_waw_stall();
    test_err_sticky();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
